lif_neuron_array: RTL and testbench
===================================

Name: lif_neuron_array

Overview:
Time-multiplexed array of N_NEURONS leaky integrate-and-fire neurons sharing one update datapath.
- Each neuron has N_INPUTS binary synapses with signed per-synapse weights, a signed membrane potential, configurable leak shift, threshold and refractory period.
- One timestep is started through a valid/ready handshake. Neurons are updated one per cycle, then the spike vector is published with a one-cycle valid pulse.
- Next-generation successor of the single fixed-size neuron tile: generalised in neuron count and widths, and adds refractory, saturation and a runtime config port.

Parameters:
N_NEURONS, 4, number of neurons (>=1)
N_INPUTS, 4, binary inputs shared by all neurons (>=1)
W_BITS, 4, signed weight width
U_BITS, 8, signed membrane potential width (> W_BITS + clog2(N_INPUTS))
R_BITS, 2, refractory counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when cfg_valid && cfg_ready
cfg_addr  in  clog2(N_NEURONS*N_INPUTS+3)  0..N*I-1 = weight[n*N_INPUTS+i]; N*I = THETA; N*I+1 = SHIFT; N*I+2 = REFRAC
cfg_data  in  U_BITS  write data, low bits used per field
x  in  N_INPUTS  input spikes, sampled on step handshake
step_valid  in  1  request one timestep
step_ready  out  1  high only in IDLE
spikes  out  N_NEURONS  spike vector of last completed step
spikes_valid  out  1  one-cycle pulse when spikes updates
u_mon_sel  in  clog2(N_NEURONS)  monitor select
u_mon  out  U_BITS  combinational u[u_mon_sel]

Behaviour:
- Reset values:
  - u[*]=0, rcnt[*]=0, weight[*]=+1, THETA=2, SHIFT=0 (3 bits), REFRAC=0.
  - spikes=0, spikes_valid=0, state IDLE, step_ready=1, cfg_ready=1.
- Reset mid-step aborts the step; no spikes_valid is produced.
- FSM: IDLE -> RUN on step_valid&&step_ready. x is latched and idx=0.
  - RUN updates neuron idx each cycle; after idx=N_NEURONS-1 -> DONE.
  - DONE: spikes register loaded, spikes_valid=1 for one cycle -> IDLE.
  - Latency: handshake in cycle T, neuron k written at end of T+1+k, spikes_valid high in cycle T+N_NEURONS+1.
  - Next step can be accepted the cycle after DONE.
- cfg_ready = (state==IDLE). Writes to unmapped addresses are ignored.
  - Simultaneous cfg and step handshake in IDLE: the config write takes effect before the step's first update.
- Neuron update, all signed arithmetic:
  - leak = (SHIFT==0) ? 0 : u >>> SHIFT (arithmetic).
  - ul = u - leak.
  - sum = sum over i of (x[i] ? weight[n][i] : 0), width W_BITS+clog2(N_INPUTS).
  - If rcnt>0: u' = ul, rcnt' = rcnt-1, spike=0. Inputs are ignored.
  - Else: us = sat_U(ul + sum).
    - If us >= THETA: spike=1, u' = sat_U(us - THETA), rcnt' = REFRAC.
    - Otherwise spike=0, u' = us.
  - sat_U clamps to [-2^(U_BITS-1), 2^(U_BITS-1)-1].
  - THETA is interpreted as signed U_BITS.
- spikes[n] holds its value until the next DONE.

Decomposition:
- Package lif_pkg: clog2-based width helpers, cfg address offsets (ADDR_THETA, ADDR_SHIFT, ADDR_REFRAC relative to N*I), reset defaults, FSM state enum {IDLE, RUN, DONE}, saturating-add function.
- Sub-module lif_update: purely combinational single-neuron datapath.
  - Inputs: u, rcnt, weights row, x, THETA, SHIFT, REFRAC.
  - Outputs: u', rcnt', spike.
  - Instantiated once and muxed by idx.

Test Plan:
1. Reset defaults, x=4'b0011, one step -> spikes_valid at T+5, spikes=4'b1111, all u_mon=0.
2. Defaults, x=4'b0001, two steps:
   - step 1 -> spikes=0, u=1.
   - step 2 -> spikes=4'b1111, u=0.
3. REFRAC=2, x=4'b1111, four steps:
   - step 1 spikes=1111, u=2.
   - steps 2–3 spikes=0, u stays 2.
   - step 4 spikes=1111, u=4.
4. THETA=100, SHIFT=1, weight[0]=7, step with x=0001, then four steps with x=0 -> u_mon(0) sequence 7, 4, 2, 1, 1.
5. All weights -8 (0x8), x=1111, five steps -> u: -32, -64, -96, -128, -128 (saturated), never spikes.
6. Assert cfg_valid during RUN -> cfg_ready=0 until IDLE. The write lands after DONE and affects only the next step.
   - Reset asserted mid-RUN -> no spikes_valid, all u=0.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types, address map, reset defaults and helpers
// for the time-multiplexed LIF neuron array.
package lif_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int ADDR_THETA  = 0;
    localparam int ADDR_SHIFT  = 1;
    localparam int ADDR_REFRAC = 2;
    localparam int N_CFG_REGS  = 3;

    localparam int SHIFT_BITS  = 3;

    localparam int RST_WEIGHT  = 1;
    localparam int RST_THETA   = 2;
    localparam int RST_SHIFT   = 0;
    localparam int RST_REFRAC  = 0;

    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Add and clamp to a signed range of the given bit width.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 bits
    );
        logic signed [31:0] s;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        s  = a + b;
        hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/lif_neuron_array_update.sv
// Combinational single-neuron leak / integrate / fire datapath,
// shared by all neurons of the array.
module lif_update
    import lif_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int W_BITS   = 4,
    parameter int U_BITS   = 8,
    parameter int R_BITS   = 2
) (
    input  logic signed [U_BITS-1:0]          u_i,
    input  logic        [R_BITS-1:0]          rcnt_i,
    input  logic        [N_INPUTS*W_BITS-1:0] w_i,
    input  logic        [N_INPUTS-1:0]        x_i,
    input  logic signed [U_BITS-1:0]          theta_i,
    input  logic        [SHIFT_BITS-1:0]      shift_i,
    input  logic        [R_BITS-1:0]          refrac_i,
    output logic signed [U_BITS-1:0]          u_o,
    output logic        [R_BITS-1:0]          rcnt_o,
    output logic                              spike_o
);

    logic signed [31:0] u_ext;
    logic signed [31:0] leak;
    logic signed [31:0] ul;
    logic signed [31:0] sum;
    logic signed [31:0] th;
    logic signed [31:0] us;
    logic signed [31:0] ut;

    always_comb begin
        u_ext = 32'(u_i);
        th    = 32'(theta_i);
        leak  = (shift_i == '0) ? 32'sd0 : (u_ext >>> shift_i);
        ul    = u_ext - leak;

        sum = 32'sd0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (x_i[i]) begin
                sum = sum + 32'($signed(w_i[i*W_BITS +: W_BITS]));
            end
        end

        us = sat_add(ul, sum, U_BITS);
        ut = sat_add(us, -th, U_BITS);

        u_o     = ul[U_BITS-1:0];
        rcnt_o  = rcnt_i;
        spike_o = 1'b0;

        // Refractory neurons only leak; their inputs are discarded.
        if (rcnt_i != '0) begin
            rcnt_o = rcnt_i - R_BITS'(1);
        end else if (us >= th) begin
            spike_o = 1'b1;
            u_o     = ut[U_BITS-1:0];
            rcnt_o  = refrac_i;
        end else begin
            u_o = us[U_BITS-1:0];
        end
    end

endmodule

// File: rtl/lif_neuron_array.sv
// Array of LIF neurons updated one per cycle through a shared
// datapath; config port is open only while idle.
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter  int N_NEURONS = 4,
    parameter  int N_INPUTS  = 4,
    parameter  int W_BITS    = 4,
    parameter  int U_BITS    = 8,
    parameter  int R_BITS    = 2,
    localparam int NW        = N_NEURONS * N_INPUTS,
    localparam int A_W       = width_of(NW + N_CFG_REGS),
    localparam int S_W       = width_of(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [A_W-1:0]       cfg_addr,
    input  logic [U_BITS-1:0]    cfg_data,
    input  logic [N_INPUTS-1:0]  x,
    input  logic                 step_valid,
    output logic                 step_ready,
    output logic [N_NEURONS-1:0] spikes,
    output logic                 spikes_valid,
    input  logic [S_W-1:0]       u_mon_sel,
    output logic [U_BITS-1:0]    u_mon
);

    state_e state_q, state_d;

    logic [S_W-1:0]       idx_q, idx_d;
    logic [N_INPUTS-1:0]  x_q, x_d;
    logic [N_NEURONS-1:0] acc_q, acc_d;
    logic [N_NEURONS-1:0] spikes_q, spikes_d;
    logic                 spikes_valid_q, spikes_valid_d;

    logic signed [U_BITS-1:0] u_q    [N_NEURONS];
    logic signed [U_BITS-1:0] u_d    [N_NEURONS];
    logic        [R_BITS-1:0] rcnt_q [N_NEURONS];
    logic        [R_BITS-1:0] rcnt_d [N_NEURONS];
    logic        [W_BITS-1:0] w_q    [NW];
    logic        [W_BITS-1:0] w_d    [NW];

    logic signed [U_BITS-1:0]     theta_q, theta_d;
    logic        [SHIFT_BITS-1:0] shift_q, shift_d;
    logic        [R_BITS-1:0]     refrac_q, refrac_d;

    logic signed [U_BITS-1:0]          sel_u;
    logic        [R_BITS-1:0]          sel_rcnt;
    logic        [N_INPUTS*W_BITS-1:0] sel_row;
    logic signed [U_BITS-1:0]          upd_u;
    logic        [R_BITS-1:0]          upd_rcnt;
    logic                              upd_spike;
    logic                              cfg_go;

    // Operand mux for the neuron currently addressed by idx.
    always_comb begin
        sel_u    = '0;
        sel_rcnt = '0;
        sel_row  = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            if (k == int'(idx_q)) begin
                sel_u    = u_q[k];
                sel_rcnt = rcnt_q[k];
                for (int i = 0; i < N_INPUTS; i++) begin
                    sel_row[i*W_BITS +: W_BITS] = w_q[k*N_INPUTS + i];
                end
            end
        end
    end

    lif_update #(
        .N_INPUTS (N_INPUTS),
        .W_BITS   (W_BITS),
        .U_BITS   (U_BITS),
        .R_BITS   (R_BITS)
    ) u_update (
        .u_i      (sel_u),
        .rcnt_i   (sel_rcnt),
        .w_i      (sel_row),
        .x_i      (x_q),
        .theta_i  (theta_q),
        .shift_i  (shift_q),
        .refrac_i (refrac_q),
        .u_o      (upd_u),
        .rcnt_o   (upd_rcnt),
        .spike_o  (upd_spike)
    );

    assign cfg_go = cfg_valid && (state_q == IDLE);

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        x_d            = x_q;
        acc_d          = acc_q;
        spikes_d       = spikes_q;
        spikes_valid_d = 1'b0;
        u_d            = u_q;
        rcnt_d         = rcnt_q;
        w_d            = w_q;
        theta_d        = theta_q;
        shift_d        = shift_q;
        refrac_d       = refrac_q;

        if (cfg_go) begin
            for (int k = 0; k < NW; k++) begin
                if (int'(cfg_addr) == k) begin
                    w_d[k] = cfg_data[W_BITS-1:0];
                end
            end
            if (int'(cfg_addr) == NW + ADDR_THETA) begin
                theta_d = cfg_data;
            end
            if (int'(cfg_addr) == NW + ADDR_SHIFT) begin
                shift_d = cfg_data[SHIFT_BITS-1:0];
            end
            if (int'(cfg_addr) == NW + ADDR_REFRAC) begin
                refrac_d = cfg_data[R_BITS-1:0];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (step_valid) begin
                    state_d = RUN;
                    idx_d   = '0;
                    x_d     = x;
                    acc_d   = '0;
                end
            end
            RUN: begin
                for (int k = 0; k < N_NEURONS; k++) begin
                    if (k == int'(idx_q)) begin
                        u_d[k]    = upd_u;
                        rcnt_d[k] = upd_rcnt;
                        acc_d[k]  = upd_spike;
                    end
                end
                // Publish on entry to DONE so the pulse lines up with it.
                if (idx_q == S_W'(N_NEURONS - 1)) begin
                    state_d        = DONE;
                    spikes_d       = acc_d;
                    spikes_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + S_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            x_q            <= '0;
            acc_q          <= '0;
            spikes_q       <= '0;
            spikes_valid_q <= 1'b0;
            theta_q        <= U_BITS'(RST_THETA);
            shift_q        <= SHIFT_BITS'(RST_SHIFT);
            refrac_q       <= R_BITS'(RST_REFRAC);
            for (int k = 0; k < N_NEURONS; k++) begin
                u_q[k]    <= '0;
                rcnt_q[k] <= '0;
            end
            for (int k = 0; k < NW; k++) begin
                w_q[k] <= W_BITS'(RST_WEIGHT);
            end
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            x_q            <= x_d;
            acc_q          <= acc_d;
            spikes_q       <= spikes_d;
            spikes_valid_q <= spikes_valid_d;
            theta_q        <= theta_d;
            shift_q        <= shift_d;
            refrac_q       <= refrac_d;
            u_q            <= u_d;
            rcnt_q         <= rcnt_d;
            w_q            <= w_d;
        end
    end

    always_comb begin
        u_mon = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            if (k == int'(u_mon_sel)) begin
                u_mon = u_q[k];
            end
        end
    end

    assign step_ready   = (state_q == IDLE);
    assign cfg_ready    = (state_q == IDLE);
    assign spikes       = spikes_q;
    assign spikes_valid = spikes_valid_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array: directed scenarios
// plus randomized steps against an integer reference model.
module tb_lif_neuron_array;

    localparam int N  = 4;
    localparam int I  = 4;
    localparam int NI = N * I;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [4:0] cfg_addr;
    logic [7:0] cfg_data;
    logic [3:0] x;
    logic       step_valid;
    logic       step_ready;
    logic [3:0] spikes;
    logic       spikes_valid;
    logic [1:0] u_mon_sel;
    logic [7:0] u_mon;

    int checks = 0;
    int errors = 0;

    // Reference model state, plain integers.
    int mu  [N];
    int mr  [N];
    int mw  [NI];
    int mth;
    int msh;
    int mref;

    lif_neuron_array dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .x            (x),
        .step_valid   (step_valid),
        .step_ready   (step_ready),
        .spikes       (spikes),
        .spikes_valid (spikes_valid),
        .u_mon_sel    (u_mon_sel),
        .u_mon        (u_mon)
    );

    always #5 clk = ~clk;

    function automatic int clampu(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic void model_reset();
        for (int n = 0; n < N; n++) begin
            mu[n] = 0;
            mr[n] = 0;
        end
        for (int k = 0; k < NI; k++) mw[k] = 1;
        mth  = 2;
        msh  = 0;
        mref = 0;
    endfunction

    function automatic void model_cfg(input int addr, input logic [7:0] d);
        logic [3:0] wl;
        wl = d[3:0];
        if (addr < NI) mw[addr] = int'($signed(wl));
        else if (addr == NI) mth = int'($signed(d));
        else if (addr == NI + 1) msh = int'(d[2:0]);
        else if (addr == NI + 2) mref = int'(d[1:0]);
    endfunction

    function automatic logic [3:0] model_step(input logic [3:0] xv);
        logic [3:0] sp;
        int ul;
        int s;
        int us;
        sp = '0;
        for (int n = 0; n < N; n++) begin
            ul = mu[n] - ((msh == 0) ? 0 : (mu[n] >>> msh));
            if (mr[n] > 0) begin
                mu[n] = ul;
                mr[n] = mr[n] - 1;
            end else begin
                s = 0;
                for (int i = 0; i < I; i++) if (xv[i]) s += mw[n*I + i];
                us = clampu(ul + s);
                if (us >= mth) begin
                    sp[n] = 1'b1;
                    mu[n] = clampu(us - mth);
                    mr[n] = mref;
                end else begin
                    mu[n] = us;
                end
            end
        end
        return sp;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset      = 1'b1;
        cfg_valid  = 1'b0;
        step_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic cfg_write(input int addr, input logic [7:0] d);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_addr  = 5'(addr);
        cfg_data  = d;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        model_cfg(addr, d);
    endtask

    task automatic read_u(input int n, output int v);
        u_mon_sel = 2'(n);
        #1 v = int'($signed(u_mon));
    endtask

    // Runs one step; lat is cycles from handshake to pulse, -1 on timeout.
    task automatic do_step(input logic [3:0] xv, output int lat,
                           output logic [3:0] sp, output logic after);
        int guard;
        @(negedge clk);
        x          = xv;
        step_valid = 1'b1;
        guard      = 0;
        while (!step_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 step_valid = 1'b0;
        x   = ~xv;
        lat = -1;
        sp  = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (spikes_valid) begin
                lat = k;
                sp  = spikes;
                break;
            end
        end
        @(negedge clk);
        after = spikes_valid;
    endtask

    task automatic test_reset();
        int v;
        apply_reset();
        checks++;
        if (step_ready !== 1'b1 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b%b expected 11", step_ready, cfg_ready);
        end
        checks++;
        if (spikes !== 4'b0 || spikes_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_spikes: got %b/%b expected 0000/0", spikes, spikes_valid);
        end
        for (int n = 0; n < N; n++) begin
            read_u(n, v);
            checks++;
            if (v !== 0) begin
                errors++;
                $display("FAIL reset_u%0d: got %0d expected 0", n, v);
            end
        end
    endtask

    task automatic test_single_step();
        int lat;
        int v;
        logic [3:0] sp;
        logic after;
        do_step(4'b0011, lat, sp, after);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL latency: got %0d expected 5", lat);
        end
        checks++;
        if (sp !== 4'b1111) begin
            errors++;
            $display("FAIL single_spikes: got %b expected 1111", sp);
        end
        checks++;
        if (after !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: got %b expected 0", after);
        end
        for (int n = 0; n < N; n++) begin
            read_u(n, v);
            checks++;
            if (v !== 0) begin
                errors++;
                $display("FAIL single_u%0d: got %0d expected 0", n, v);
            end
        end
    endtask

    task automatic test_two_steps();
        int lat;
        int v;
        logic [3:0] sp;
        logic after;
        logic [3:0] exp_sp [2] = '{4'b0000, 4'b1111};
        int exp_u [2] = '{1, 0};
        apply_reset();
        for (int s = 0; s < 2; s++) begin
            do_step(4'b0001, lat, sp, after);
            checks++;
            if (sp !== exp_sp[s] || lat !== 5) begin
                errors++;
                $display("FAIL two_step%0d: got %b lat %0d expected %b lat 5", s, sp, lat, exp_sp[s]);
            end
            for (int n = 0; n < N; n++) begin
                read_u(n, v);
                checks++;
                if (v !== exp_u[s]) begin
                    errors++;
                    $display("FAIL two_step%0d_u%0d: got %0d expected %0d", s, n, v, exp_u[s]);
                end
            end
        end
    endtask

    task automatic test_refrac();
        int lat;
        int v;
        logic [3:0] sp;
        logic after;
        logic [3:0] exp_sp [4] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111};
        int exp_u [4] = '{2, 2, 2, 4};
        apply_reset();
        cfg_write(NI + 2, 8'd2);
        for (int s = 0; s < 4; s++) begin
            do_step(4'b1111, lat, sp, after);
            checks++;
            if (sp !== exp_sp[s]) begin
                errors++;
                $display("FAIL refrac_step%0d: got %b expected %b", s, sp, exp_sp[s]);
            end
            read_u(s, v);
            checks++;
            if (v !== exp_u[s]) begin
                errors++;
                $display("FAIL refrac_u step%0d: got %0d expected %0d", s, v, exp_u[s]);
            end
        end
    endtask

    task automatic test_leak();
        int lat;
        int v;
        logic [3:0] sp;
        logic after;
        int exp_u [5] = '{7, 4, 2, 1, 1};
        apply_reset();
        cfg_write(NI, 8'd100);
        cfg_write(NI + 1, 8'd1);
        cfg_write(0, 8'd7);
        for (int s = 0; s < 5; s++) begin
            do_step((s == 0) ? 4'b0001 : 4'b0000, lat, sp, after);
            read_u(0, v);
            checks++;
            if (v !== exp_u[s] || sp !== 4'b0) begin
                errors++;
                $display("FAIL leak_step%0d: got u %0d sp %b expected u %0d sp 0000", s, v, sp, exp_u[s]);
            end
        end
    endtask

    task automatic test_saturation();
        int lat;
        int v;
        logic [3:0] sp;
        logic after;
        int exp_u [5] = '{-32, -64, -96, -128, -128};
        apply_reset();
        for (int k = 0; k < NI; k++) cfg_write(k, 8'h08);
        for (int s = 0; s < 5; s++) begin
            do_step(4'b1111, lat, sp, after);
            checks++;
            if (sp !== 4'b0) begin
                errors++;
                $display("FAIL sat_spikes%0d: got %b expected 0000", s, sp);
            end
            for (int n = 0; n < N; n++) begin
                read_u(n, v);
                checks++;
                if (v !== exp_u[s]) begin
                    errors++;
                    $display("FAIL sat_step%0d_u%0d: got %0d expected %0d", s, n, v, exp_u[s]);
                end
            end
        end
    endtask

    task automatic test_cfg_during_run();
        int lat;
        int blocked;
        int v;
        logic [3:0] sp;
        logic after;
        apply_reset();
        @(negedge clk);
        x          = 4'b0011;
        step_valid = 1'b1;
        @(posedge clk);
        #1 step_valid = 1'b0;
        cfg_valid = 1'b1;
        cfg_addr  = 5'(NI);
        cfg_data  = 8'd100;
        blocked   = 0;
        lat       = -1;
        sp        = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!cfg_ready) blocked++;
            if (spikes_valid) begin
                lat = k;
                sp  = spikes;
                break;
            end
        end
        checks++;
        if (lat !== 5 || blocked !== 5 || sp !== 4'b1111) begin
            errors++;
            $display("FAIL cfg_block: got lat %0d blocked %0d sp %b expected 5 5 1111", lat, blocked, sp);
        end
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_reopen: got %b expected 1", cfg_ready);
        end
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        model_cfg(NI, 8'd100);
        do_step(4'b0011, lat, sp, after);
        checks++;
        if (sp !== 4'b0) begin
            errors++;
            $display("FAIL cfg_next_step: got %b expected 0000", sp);
        end
        read_u(2, v);
        checks++;
        if (v !== 2) begin
            errors++;
            $display("FAIL cfg_next_u: got %0d expected 2", v);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int v;
        logic [3:0] sp;
        logic after;
        logic seen;
        apply_reset();
        do_step(4'b0001, lat, sp, after);
        @(negedge clk);
        x          = 4'b1111;
        step_valid = 1'b1;
        @(posedge clk);
        #1 step_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            seen |= spikes_valid;
        end
        checks++;
        if (seen !== 1'b0 || step_ready !== 1'b1 || spikes !== 4'b0) begin
            errors++;
            $display("FAIL mid_reset: got valid %b ready %b sp %b expected 0 1 0000", seen, step_ready, spikes);
        end
        for (int n = 0; n < N; n++) begin
            read_u(n, v);
            checks++;
            if (v !== 0) begin
                errors++;
                $display("FAIL mid_reset_u%0d: got %0d expected 0", n, v);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        int v;
        logic [3:0] sp;
        logic [3:0] exp_sp;
        logic [3:0] xv;
        logic after;
        apply_reset();
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) < 4) begin
                cfg_write(int'($urandom_range(0, 31)), 8'($urandom));
            end
            if ($urandom_range(0, 9) == 0) begin
                cfg_write(NI, 8'($urandom_range(0, 12)));
            end
            xv = 4'($urandom);
            do_step(xv, lat, sp, after);
            exp_sp = model_step(xv);
            checks++;
            if (sp !== exp_sp || lat !== 5) begin
                errors++;
                $display("FAIL rand%0d_spikes: got %b lat %0d expected %b lat 5", it, sp, lat, exp_sp);
            end
            for (int n = 0; n < N; n++) begin
                read_u(n, v);
                checks++;
                if (v !== mu[n]) begin
                    errors++;
                    $display("FAIL rand%0d_u%0d: got %0d expected %0d", it, n, v, mu[n]);
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        cfg_valid  = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        x          = '0;
        step_valid = 1'b0;
        u_mon_sel  = '0;
        model_reset();
        test_reset();
        test_single_step();
        test_two_steps();
        test_refrac();
        test_leak();
        test_saturation();
        test_cfg_during_run();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
